// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: accepts parallel words, serializes them MSB-first,
// runs an overlapping programmable pattern match (1..8 bits) over the bit
// stream and reports a saturating per-word match count.
module pattern_scan_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [7:0]        cfg_pattern,
    input  logic [2:0]        cfg_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ser_bit,
    output logic              ser_vld,
    output logic              match,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_cnt,
    input  logic              out_ready,
    output logic              busy
);

    localparam int K_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [K_W-1:0]   K_LAST  = K_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_REPORT} state_t;

    state_t             state_reg, state_next;
    logic [DATA_W-1:0]  shift_reg;
    logic [K_W-1:0]     k_reg;
    logic [7:0]         hist_reg;
    logic [3:0]         fill_reg;
    logic [7:0]         pattern_reg;
    logic [2:0]         len_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               match_reg;

    logic               accept;
    logic [7:0]         hist_next;
    logic [3:0]         fill_next;
    logic [3:0]         len_plus1;
    logic [7:0]         mask;
    logic               hit;
    logic [CNT_W-1:0]   cnt_next;

    // Compare mask: bit gi participates when it lies within the pattern length.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mask
            assign mask[gi] = (3'(gi) <= len_reg);
        end
    endgenerate

    // Match evaluation on the history as it will look after the current bit.
    always_comb begin
        hist_next = {hist_reg[6:0], shift_reg[DATA_W-1]};
        fill_next = (fill_reg == 4'd8) ? 4'd8 : fill_reg + 4'd1;
        len_plus1 = {1'b0, len_reg} + 4'd1;
        hit       = (((hist_next ^ pattern_reg) & mask) == 8'd0) && (fill_next >= len_plus1);
        cnt_next  = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(hit);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state decode and handshake/serial outputs.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        ser_vld    = 1'b0;
        ser_bit    = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                ser_vld = 1'b1;
                ser_bit = shift_reg[DATA_W-1];
                if (k_reg == K_LAST) state_next = ST_REPORT;
            end
            ST_REPORT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: config latch, shifting, history, match pulse and word count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            k_reg       <= '0;
            hist_reg    <= 8'd0;
            fill_reg    <= 4'd0;
            pattern_reg <= 8'b0000_0101;
            len_reg     <= 3'd2;
            cnt_reg     <= '0;
            match_reg   <= 1'b0;
        end else begin
            match_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_we) begin
                        pattern_reg <= cfg_pattern;
                        len_reg     <= cfg_len;
                        hist_reg    <= 8'd0;
                        fill_reg    <= 4'd0;
                    end
                    if (accept) begin
                        shift_reg <= in_data;
                        k_reg     <= '0;
                        cnt_reg   <= '0;
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                    hist_reg  <= hist_next;
                    fill_reg  <= fill_next;
                    k_reg     <= k_reg + K_W'(1);
                    match_reg <= hit;
                    cnt_reg   <= cnt_next;
                end
                default: ;
            endcase
        end
    end

    assign match   = match_reg;
    assign out_cnt = out_valid ? cnt_reg : '0;
    assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: default pattern, straddling words,
// reconfiguration, backpressure, saturation and mid-word reset.
module tb_pattern_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we, cfg_we2;
    logic [7:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic       in_valid, in_valid2;
    logic [7:0] in_data;
    logic       out_ready;
    logic       in_ready, ser_bit, ser_vld, match, out_valid, busy;
    logic [3:0] out_cnt;
    logic       in_ready2, ser_bit2, ser_vld2, match2, out_valid2, busy2;
    logic [1:0] out_cnt2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pattern_scan_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ser_bit(ser_bit), .ser_vld(ser_vld), .match(match),
        .out_valid(out_valid), .out_cnt(out_cnt), .out_ready(out_ready), .busy(busy)
    );

    pattern_scan_ctrl #(.DATA_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we2), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .in_valid(in_valid2), .in_data(in_data),
        .in_ready(in_ready2), .ser_bit(ser_bit2), .ser_vld(ser_vld2), .match(match2),
        .out_valid(out_valid2), .out_cnt(out_cnt2), .out_ready(1'b1), .busy(busy2)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_we2 = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
        in_data = 8'h00; cfg_pattern = 8'h00; cfg_len = 3'd0; out_ready = 1'b1;
        step; step;
        rst_n = 1'b1;
        step;
    endtask

    // Accepts one word in the current cycle T and collects bits, match pulses
    // and report-cycle status up to cycle T+9 (left in that cycle).
    task automatic run_word(input logic [7:0] d, output logic [7:0] bits,
                            output logic [7:0] hits, output logic [3:0] cnt,
                            output logic vt_early, output logic vt, output logic rdy_late);
        bits = 8'h00; hits = 8'h00; vt_early = 1'b0;
        in_valid = 1'b1; in_data = d;
        step;
        in_valid = 1'b0; cfg_we = 1'b0; in_data = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            bits[7-k] = ser_bit;
            if (k > 0) hits[k-1] = match;
            if (k == 7) vt_early = out_valid;
            step;
        end
        hits[7]  = match;
        vt       = out_valid;
        cnt      = out_cnt;
        rdy_late = in_ready;
        $display("[TB] word %h -> bits %h hits %h cnt %0d", d, bits, hits, cnt);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_we2 = 1'b0; in_valid2 = 1'b0;
        cfg_pattern = 8'h00; cfg_len = 3'd0; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hFF;
        step; step;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if ({ser_vld, ser_bit, match, out_valid} !== 4'b0000) begin tests_failed++; $display("FAIL reset_outs: got %b expected 0000", {ser_vld, ser_bit, match, out_valid}); end
        tests_run++; if (out_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset_out_cnt: got %0d expected 0", out_cnt); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        step;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
        $display("[TB] reset checked");
    endtask

    task automatic test_default_pattern;
        logic [7:0] bits, hits; logic [3:0] cnt; logic ve, vt, rl;
        do_reset;
        run_word(8'b1010_1000, bits, hits, cnt, ve, vt, rl);
        tests_run++; if (bits !== 8'hA8) begin tests_failed++; $display("FAIL default_bits: got %h expected a8", bits); end
        tests_run++; if (hits !== 8'h14) begin tests_failed++; $display("FAIL default_match: got %h expected 14", hits); end
        tests_run++; if (ve !== 1'b0 || vt !== 1'b1) begin tests_failed++; $display("FAIL default_out_valid_timing: got %b%b expected 01", ve, vt); end
        tests_run++; if (cnt !== 4'd2) begin tests_failed++; $display("FAIL default_cnt: got %0d expected 2", cnt); end
        tests_run++; if (rl !== 1'b0) begin tests_failed++; $display("FAIL default_in_ready_report: got %b expected 0", rl); end
        step;
        tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL default_return_idle: got %b%b expected 10", in_ready, out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bits, hits; logic [3:0] cnt; logic ve, vt, rl;
        do_reset;
        run_word(8'b0000_0010, bits, hits, cnt, ve, vt, rl);
        tests_run++; if (cnt !== 4'd0 || hits !== 8'h00) begin tests_failed++; $display("FAIL straddle_w1: got cnt %0d hits %h expected 0 00", cnt, hits); end
        step;
        run_word(8'b1000_0000, bits, hits, cnt, ve, vt, rl);
        tests_run++; if (cnt !== 4'd1) begin tests_failed++; $display("FAIL straddle_w2_cnt: got %0d expected 1", cnt); end
        tests_run++; if (hits !== 8'h01) begin tests_failed++; $display("FAIL straddle_w2_match: got %h expected 01", hits); end
        step;
    endtask

    task automatic test_config;
        logic [7:0] bits, hits; logic [3:0] cnt; logic ve, vt, rl;
        do_reset;
        cfg_we = 1'b1; cfg_pattern = 8'hA5; cfg_len = 3'd7;
        run_word(8'hA5, bits, hits, cnt, ve, vt, rl);
        tests_run++; if (hits !== 8'h80) begin tests_failed++; $display("FAIL cfg8_match: got %h expected 80", hits); end
        tests_run++; if (cnt !== 4'd1) begin tests_failed++; $display("FAIL cfg8_cnt: got %0d expected 1", cnt); end
        step;
        cfg_we = 1'b1; cfg_pattern = 8'h01; cfg_len = 3'd0;
        step;
        cfg_we = 1'b0;
        run_word(8'hFF, bits, hits, cnt, ve, vt, rl);
        tests_run++; if (hits !== 8'hFF) begin tests_failed++; $display("FAIL cfg1_match: got %h expected ff", hits); end
        tests_run++; if (cnt !== 4'd8) begin tests_failed++; $display("FAIL cfg1_cnt: got %0d expected 8", cnt); end
        step;
    endtask

    task automatic test_backpressure;
        logic [7:0] bits, hits; logic [3:0] cnt; logic ve, vt, rl;
        do_reset;
        out_ready = 1'b0;
        run_word(8'b1010_1010, bits, hits, cnt, ve, vt, rl);
        tests_run++; if (hits !== 8'h54 || cnt !== 4'd3) begin tests_failed++; $display("FAIL bp_word: got hits %h cnt %0d expected 54 3", hits, cnt); end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; cfg_we = 1'b1; cfg_pattern = 8'h03; cfg_len = 3'd1; in_data = 8'hFF;
            step;
            tests_run++;
            if (out_valid !== 1'b1 || out_cnt !== 4'd3 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: got valid %b cnt %0d ready %b expected 1 3 0", i, out_valid, out_cnt, in_ready);
            end
        end
        in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1; cfg_pattern = 8'h00; cfg_len = 3'd0;
        step;
        tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release: got %b%b expected 10", in_ready, out_valid); end
        run_word(8'b1010_0000, bits, hits, cnt, ve, vt, rl);
        tests_run++; if (cnt !== 4'd2 || hits !== 8'h05) begin tests_failed++; $display("FAIL bp_cfg_ignored: got cnt %0d hits %h expected 2 05", cnt, hits); end
        step;
    endtask

    task automatic test_saturation;
        int pulses;
        do_reset;
        cfg_we2 = 1'b1; cfg_pattern = 8'h01; cfg_len = 3'd0;
        in_valid2 = 1'b1; in_data = 8'hFF;
        step;
        cfg_we2 = 1'b0; in_valid2 = 1'b0; in_data = 8'h00;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step;
            if (match2 === 1'b1) pulses++;
        end
        $display("[TB] sat word ff -> pulses %0d cnt %0d", pulses, out_cnt2);
        tests_run++; if (pulses != 8) begin tests_failed++; $display("FAIL sat_pulses: got %0d expected 8", pulses); end
        tests_run++; if (out_valid2 !== 1'b1 || out_cnt2 !== 2'd3) begin tests_failed++; $display("FAIL sat_cnt: got valid %b cnt %0d expected 1 3", out_valid2, out_cnt2); end
        step;
    endtask

    task automatic test_reset_mid_word;
        logic [7:0] bits, hits; logic [3:0] cnt; logic ve, vt, rl;
        do_reset;
        cfg_we = 1'b1; cfg_pattern = 8'h03; cfg_len = 3'd1;
        step;
        cfg_we = 1'b0;
        in_valid = 1'b1; in_data = 8'b1100_0000;
        step;
        in_valid = 1'b0;
        step; step; step;
        tests_run++; if (busy !== 1'b1 || ser_vld !== 1'b1) begin tests_failed++; $display("FAIL midrst_pre: got busy %b ser_vld %b expected 1 1", busy, ser_vld); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, ser_vld, ser_bit, match, out_valid} !== 5'b00000 || out_cnt !== 4'd0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_async: got %b cnt %0d ready %b expected 00000 0 1", {busy, ser_vld, ser_bit, match, out_valid}, out_cnt, in_ready);
        end
        step;
        rst_n = 1'b1;
        step;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        run_word(8'b0000_0101, bits, hits, cnt, ve, vt, rl);
        tests_run++; if (cnt !== 4'd1 || hits !== 8'h80) begin tests_failed++; $display("FAIL midrst_defaults: got cnt %0d hits %h expected 1 80", cnt, hits); end
        step;
    endtask

    initial begin
        test_reset;
        test_default_pattern;
        test_back_to_back;
        test_config;
        test_backpressure;
        test_saturation;
        test_reset_mid_word;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Word-level controller for the serial sequence detector. It accepts parallel words over a valid/ready handshake and serializes each one MSB-first onto a bit line. It runs a programmable overlapping pattern match (1–8 bits; reset default `101`) on that stream and returns a per-word match count over a second valid/ready handshake. It sits between the word-oriented bus side and the bit-serial detection path, and sequences and configures that path.

## Interface
- `DATA_W`, 8: input word width, ≥2.
- `CNT_W`, 4: match-count width; count saturates at 2^CNT_W−1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `cfg_we` in 1: latch `cfg_pattern`/`cfg_len`; honoured only in IDLE.
- `cfg_pattern` in 8: pattern, right-aligned (bit 0 = last bit in time).
- `cfg_len` in 3: pattern length minus 1 (0..7 → 1..8 bits).
- `in_valid` in 1, `in_data` in DATA_W, `in_ready` out 1: word input handshake.
- `ser_bit` out 1, `ser_vld` out 1: bit currently being scanned.
- `match` out 1: registered pulse, pattern completed on previous `ser_bit`.
- `out_valid` out 1, `out_cnt` out CNT_W, `out_ready` in 1: count output handshake.
- `busy` out 1: state ≠ IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1.
    - `in_valid`&`in_ready` → SHIFT. Load shift reg with `in_data`, bit index k=0, word count=0.
  - SHIFT: `ser_vld`=1, `ser_bit`=shift-reg MSB.
    - Each edge: shift left, history `hist` ← {hist[6:0], ser_bit}, `fill` ← min(fill+1, 8), k+1.
    - After k=DATA_W−1 → REPORT.
  - REPORT: `out_valid`=1, `out_cnt`=word count.
    - `out_valid`&`out_ready` → IDLE.
- Match rule, evaluated on the updated `hist`/`fill`: mask = 2^(len+1)−1; hit = ((hist ^ pattern) & mask)==0 && fill ≥ len+1.
  - `match` ← hit; word count ← sat(count+hit).
  - Matches overlap.
- History persists across words. A pattern straddling two words counts in the word containing its completing bit.
- Config write (`cfg_we` in IDLE):
  - Latch pattern and length.
  - Clear `hist` and `fill` at the same edge.
  - If a transfer is also accepted at that edge, the word uses the new config.
- `cfg_we` in SHIFT/REPORT is ignored (no latch, no history clear).
- `in_valid` outside IDLE is ignored; `in_data` is sampled only at the accept edge.
- `out_cnt` and `out_valid` hold stable while `out_ready`=0.

## Timing
- Reset (async assert, sync release), all values take effect immediately:
  - state=IDLE; `hist`=0; `fill`=0.
  - pattern=8'b0000_0101, len=2.
  - `match`, `ser_vld`, `out_valid`, `busy` = 0; `out_cnt`=0; `ser_bit`=0.
  - `in_ready`=1 (decoded from IDLE), but no transfer is taken while `rst_n`=0.
- Word accepted at edge ending cycle T:
  - bit k appears on `ser_bit` in cycle T+1+k;
  - its `match` is high in cycle T+2+k;
  - `out_valid` rises in cycle T+DATA_W+1, alongside the last bit's `match`.
- With `out_ready` held 1, `in_ready` returns in cycle T+DATA_W+2. Peak throughput is one word per DATA_W+2 cycles.
- Reset mid-SHIFT or mid-REPORT aborts the word; no count is reported. The configuration returns to defaults.
- Saturation: once the count reaches 2^CNT_W−1 it holds, while `match` keeps pulsing.

## Test plan
- Defaults, accept 8'b1010_1000 at T:
  - `ser_bit` in T+1..T+8 = 1,0,1,0,1,0,0,0;
  - `match` high only in T+4 and T+6;
  - `out_valid` in T+9 with `out_cnt`=2.
- Straddle: 8'b0000_0010 then 8'b1000_0000 → `out_cnt`=0 for word 1, then 1 for word 2, with the `match` on word 2 bit k=0.
- Config `cfg_pattern`=8'hA5, `cfg_len`=7, then word 8'hA5 → single `match` on k=7 only, `out_cnt`=1. Then `cfg_pattern`=8'h01, `cfg_len`=0, word 8'hFF → `out_cnt`=8.
- Backpressure: hold `out_ready`=0 for 5 cycles in REPORT, pulsing `in_valid` and `cfg_we` (pattern 8'h03, len 1) during that time:
  - `out_valid`/`out_cnt` stay stable, `in_ready`=0;
  - the config is unchanged (next 8'b1010_0000 gives `out_cnt`=2 with `101`).
- Saturation, with `CNT_W`=2, pattern `1` len 0, word 8'hFF → `out_cnt`=3 and eight `match` pulses.
- Reset asserted at k=3 of a word:
  - all outputs go to reset values within the cycle;
  - after release, `in_ready`=1 and the first word 8'b0000_0101 gives `out_cnt`=1 (history cleared, defaults restored).
